// File: rtl/victim_way_selector_if.sv
// Miss-controller <-> victim selector handshake bundle.
// VALID_MASK exists only when VICTIM_INVALID_FIRST_EN is defined.
interface victim_way_selector_if #(
  parameter int WAY_ORDER      = 2,
  parameter int SET_ADDR_WIDTH = 6
);
  localparam int WAYS = 1 << WAY_ORDER;
  localparam int BW   = (WAY_ORDER > 0) ? WAY_ORDER : 1;

  logic                      REQ_VALID;
  logic [SET_ADDR_WIDTH-1:0] REQ_SET;
  logic                      REQ_READY;
  logic                      VICTIM_VALID;
  logic [WAYS-1:0]           VICTIM_WAY;
  logic [BW-1:0]             VICTIM_BIN;
  logic                      COMMIT;
  logic                      ABORT;
  logic                      INIT_DONE;
`ifdef VICTIM_INVALID_FIRST_EN
  logic [WAYS-1:0]           VALID_MASK;

  modport master (output REQ_VALID, REQ_SET, COMMIT, ABORT, VALID_MASK,
                  input  REQ_READY, VICTIM_VALID, VICTIM_WAY, VICTIM_BIN, INIT_DONE);
  modport slave  (input  REQ_VALID, REQ_SET, COMMIT, ABORT, VALID_MASK,
                  output REQ_READY, VICTIM_VALID, VICTIM_WAY, VICTIM_BIN, INIT_DONE);
`else
  modport master (output REQ_VALID, REQ_SET, COMMIT, ABORT,
                  input  REQ_READY, VICTIM_VALID, VICTIM_WAY, VICTIM_BIN, INIT_DONE);
  modport slave  (input  REQ_VALID, REQ_SET, COMMIT, ABORT,
                  output REQ_READY, VICTIM_VALID, VICTIM_WAY, VICTIM_BIN, INIT_DONE);
`endif
endinterface

// File: rtl/victim_way_selector.sv
// Per-set round-robin victim selector with one-hot way output and request/hold/commit handshake.
// Optional invalid-way-first selection: define VICTIM_INVALID_FIRST_EN.
module victim_way_selector #(
  parameter int WAY_ORDER      = 2,
  parameter int SET_ADDR_WIDTH = 6
) (
  input logic CLK,
  input logic RST,
  victim_way_selector_if.slave bus
);
  localparam int WAYS = 1 << WAY_ORDER;
  localparam int PW   = (WAY_ORDER > 0) ? WAY_ORDER : 1;
  localparam int SETS = 1 << SET_ADDR_WIDTH;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_HOLD} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]             ptr_mem [SETS];
  logic [SET_ADDR_WIDTH-1:0] sweep, set_q, mem_addr;
  logic [PW-1:0]             rd_q, pick, ptr_inc, mem_wdata;
  logic                      mem_we, skip_adv, use_inv;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = sweep;
    mem_wdata = '0;
    case (state)
      S_INIT: begin
        mem_we = 1'b1;
        if (sweep == SET_ADDR_WIDTH'(SETS - 1)) state_nxt = S_IDLE;
      end
      S_IDLE:   if (bus.REQ_VALID) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = S_HOLD;
      S_HOLD: begin
        if (bus.COMMIT) begin
          mem_we    = !skip_adv;
          mem_addr  = set_q;
          mem_wdata = ptr_inc;
          state_nxt = S_IDLE;
        end else if (bus.ABORT) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  generate
    if (WAY_ORDER == 0) begin : g_one_way
      assign ptr_inc = '0;
    end else begin : g_multi_way
      assign ptr_inc = rd_q + PW'(1);
    end
  endgenerate

`ifdef VICTIM_INVALID_FIRST_EN
  // Lowest-index invalid way wins; descending scan leaves the smallest index last.
  always_comb begin
    use_inv = ~&bus.VALID_MASK;
    pick    = rd_q;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!bus.VALID_MASK[i]) pick = PW'(i);
  end
`else
  assign use_inv = 1'b0;
  assign pick    = rd_q;
`endif

  // Writes only occur in INIT/HOLD and reads only in IDLE, so a read never
  // shares an edge with a write and a commit is visible to the next request.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) ptr_mem[mem_addr] <= mem_wdata;
  end

  assign bus.REQ_READY = (state == S_IDLE) && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sweep            <= '0;
      set_q            <= '0;
      rd_q             <= '0;
      skip_adv         <= 1'b0;
      bus.VICTIM_VALID <= 1'b0;
      bus.VICTIM_WAY   <= '0;
      bus.VICTIM_BIN   <= '0;
      bus.INIT_DONE    <= 1'b0;
    end else begin
      if (state == S_INIT) sweep <= sweep + SET_ADDR_WIDTH'(1);
      if (state != S_INIT) bus.INIT_DONE <= 1'b1;
      if (state == S_IDLE && bus.REQ_VALID) begin
        set_q <= bus.REQ_SET;
        rd_q  <= ptr_mem[bus.REQ_SET];
      end
      if (state == S_LOOKUP) begin
        bus.VICTIM_VALID <= 1'b1;
        bus.VICTIM_BIN   <= pick;
        bus.VICTIM_WAY   <= WAYS'(1) << pick;
        skip_adv         <= use_inv;
      end else if (state == S_HOLD && (bus.COMMIT || bus.ABORT)) begin
        bus.VICTIM_VALID <= 1'b0;
        bus.VICTIM_WAY   <= '0;
        bus.VICTIM_BIN   <= '0;
      end
    end
  end
endmodule
